mult_share_arbiter: RTL and testbench

- Shares one registered 8-bit Wallace multiplier (`wallace1`) among `NREQ` requesters.
- Each cycle it grants at most one pending request and drives that requester's operands into the multiplier.
- It tracks the requester ID through the multiplier latency and returns each product tagged with that ID.
- Sits between the requester-side compute units and the single multiplier instance.

---
 rtl/mult_share_arbiter.sv | 105 ++++++++++
 tb/tb_mult_share_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one registered multiplier among NREQ requesters and returns ID-tagged products.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int MULT_LAT = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   x_in,
  input  logic [NREQ*WIDTH-1:0]   y_in,
  input  logic                    hold,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        mult_x,
  output logic [WIDTH-1:0]        mult_y,
  input  logic [WIDTH-1:0]        mult_product,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [WIDTH-1:0]        res_data,
  output logic                    idle
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic grant;
  logic [IDW-1:0] sel;
  logic [NREQ-1:0] gnt_n;
  logic [WIDTH-1:0] sel_x, sel_y;
  logic [MULT_LAT:0] tag_v;
  logic [IDW-1:0] tag_id [MULT_LAT+1];
`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (req[i]) sel = IDW'(i);
  end
`else
  logic [IDW-1:0] rr_ptr, rr_next;
  logic [IDW:0] sum;
  logic hit;
  // Scan from rr_ptr upward, wrapping at NREQ (NREQ need not be a power of two).
  always_comb begin
    sel = '0;
    sum = '0;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!hit && req[sum[IDW-1:0]]) begin
        hit = 1'b1;
        sel = sum[IDW-1:0];
      end
    end
    rr_next = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rr_ptr <= '0;
    else if (grant) rr_ptr <= rr_next;
`endif
  assign grant = !hold && |req;
  assign idle = state == IDLE;
  always_comb begin
    gnt_n = '0;
    sel_x = '0;
    sel_y = '0;
    if (grant) gnt_n[sel] = 1'b1;
    for (int i = 0; i < NREQ; i++)
      if (sel == IDW'(i)) begin
        sel_x = x_in[i*WIDTH +: WIDTH];
        sel_y = y_in[i*WIDTH +: WIDTH];
      end
    state_n = grant ? RUN : (state == IDLE) ? IDLE : |tag_v ? DRAIN : IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      gnt <= '0;
      mult_x <= '0;
      mult_y <= '0;
      tag_v <= '0;
      for (int i = 0; i <= MULT_LAT; i++) tag_id[i] <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_data <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      if (grant) begin
        mult_x <= sel_x;
        mult_y <= sel_y;
      end
      tag_v[0] <= grant;
      tag_id[0] <= sel;
      for (int i = 1; i <= MULT_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      // Final tag stage lines up with the multiplier's registered product.
      res_valid <= tag_v[MULT_LAT];
      if (tag_v[MULT_LAT]) begin
        res_id <= tag_id[MULT_LAT];
        res_data <= mult_product;
      end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed and random checks of mult_share_arbiter against a queue-based model.
// Honours MULT_ARB_FIXED_PRIO_EN in the model and in the literal expectations.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int MULT_LAT = 1;
  localparam int IDW = 2;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0] req;
  logic [NREQ*WIDTH-1:0] x_in, y_in;
  logic hold;
  logic [NREQ-1:0] gnt;
  logic [WIDTH-1:0] mult_x, mult_y, mult_product, res_data;
  logic res_valid, idle;
  logic [IDW-1:0] res_id;
  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .x_in(x_in), .y_in(y_in), .hold(hold),
    .gnt(gnt), .mult_x(mult_x), .mult_y(mult_y), .mult_product(mult_product),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .idle(idle)
  );
  always #5 clock = ~clock;
  // Stand-in for the shared registered multiplier.
  always_ff @(posedge clock) mult_product <= mult_x * mult_y;
  typedef struct {int due; int id; logic [WIDTH-1:0] data;} res_t;
  res_t q[$];
  int cyc, m_ptr, since, n_cmp, n_err;
  logic [NREQ-1:0] e_gnt;
  logic e_valid;
  logic [IDW-1:0] e_id;
  logic [WIDTH-1:0] e_data, e_mx, e_my;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    since = MULT_LAT + 2;
    e_gnt = '0;
    e_valid = 1'b0;
    e_mx = '0;
    e_my = '0;
  endtask
  task automatic step();
    int g, k;
    logic [2*WIDTH-1:0] p;
    res_t r;
    @(posedge clock);
    cyc++;
    g = -1;
    if (!hold)
      for (int i = 0; i < NREQ; i++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
        k = i;
`else
        k = (m_ptr + i) % NREQ;
`endif
        if (g < 0 && req[k]) g = k;
      end
    e_gnt = '0;
    e_valid = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      e_valid = 1'b1;
      e_id = IDW'(r.id);
      e_data = r.data;
    end
    if (g >= 0) begin
      e_gnt[g] = 1'b1;
      e_mx = x_in[g*WIDTH +: WIDTH];
      e_my = y_in[g*WIDTH +: WIDTH];
      p = e_mx * e_my;
      r.due = cyc + MULT_LAT + 1;
      r.id = g;
      r.data = p[WIDTH-1:0];
      q.push_back(r);
      m_ptr = (g + 1) % NREQ;
      since = 0;
    end else since++;
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("mult_x", 32'(mult_x), 32'(e_mx));
    chk("mult_y", 32'(mult_y), 32'(e_my));
    chk("res_valid", 32'(res_valid), 32'(e_valid));
    chk("idle", 32'(idle), 32'(since >= MULT_LAT + 2));
    if (e_valid) begin
      chk("res_id", 32'(res_id), 32'(e_id));
      chk("res_data", 32'(res_data), 32'(e_data));
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_mult_x", 32'(mult_x), 0);
    chk("rst_mult_y", 32'(mult_y), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_idle", 32'(idle), 1);
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask
  initial begin
    logic [WIDTH-1:0] tbl [4];
    int stale, saw2;
    tbl = '{8'h24, 8'h18, 8'hFB, 8'h02};
    req = '0;
    hold = 1'b0;
    x_in = '0;
    y_in = '0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    #12;
    do_reset();
    req = 4'b0001;
    x_in[7:0] = 8'hFE;
    y_in[7:0] = 8'h06;
    step();
    chk("single_gnt", 32'(gnt), 1);
    req = '0;
    step();
    step();
    chk("single_valid", 32'(res_valid), 1);
    chk("single_id", 32'(res_id), 0);
    chk("single_data", 32'(res_data), 32'h F4);
    step();
    chk("single_idle", 32'(idle), 1);
    do_reset();
    x_in = {8'h01, 8'h05, 8'h04, 8'h06};
    y_in = {8'h02, 8'hFF, 8'h06, 8'h06};
    req = 4'hF;
    for (int s = 0; s < 8; s++) begin
      step();
`ifdef MULT_ARB_FIXED_PRIO_EN
      chk("contend_gnt", 32'(gnt), 1);
      if (s >= 2) chk("contend_data", 32'(res_data), 32'h24);
`else
      chk("contend_gnt", 32'(gnt), 32'(1 << (s % 4)));
      if (s >= 2) chk("contend_data", 32'(res_data), 32'(tbl[(s - 2) % 4]));
`endif
    end
    req = '0;
    repeat (4) step();
    saw2 = 0;
    req = 4'b0101;
    step();
    chk("wdraw_gnt", 32'(gnt), 1);
    req = 4'b0001;
    step();
    req = '0;
    repeat (5) begin
      step();
      if (res_valid && res_id == 2) saw2++;
    end
    chk("wdraw_no_id2", 32'(saw2), 0);
    req = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      step();
`ifdef MULT_ARB_FIXED_PRIO_EN
      chk("fair_gnt", 32'(gnt), 2);
`else
      chk("fair_gnt", 32'(gnt), (s % 2 == 0) ? 2 : 8);
`endif
    end
    req = '0;
    repeat (4) step();
    req = 4'b0001;
    step();
    chk("hold_first_gnt", 32'(gnt), 1);
    hold = 1'b1;
    step();
    chk("hold_blocks", 32'(gnt), 0);
    step();
    chk("hold_drain_valid", 32'(res_valid), 1);
    chk("hold_busy", 32'(idle), 0);
    step();
    chk("hold_idle", 32'(idle), 1);
    step();
    chk("hold_still_blocked", 32'(gnt), 0);
    hold = 1'b0;
    step();
    chk("hold_resume", 32'(gnt), 1);
    req = '0;
    repeat (3) step();
    x_in = $urandom;
    y_in = $urandom;
    req = 4'hF;
    repeat (3) step();
    do_reset();
    req = '0;
    stale = 0;
    repeat (5) begin
      step();
      if (res_valid) stale++;
    end
    chk("no_stale_valid", 32'(stale), 0);
    repeat (400) begin
      req = 4'($urandom);
      hold = ($urandom_range(0, 4) == 0);
      x_in = $urandom;
      y_in = $urandom;
      step();
    end
    req = '0;
    hold = 1'b0;
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
